// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Purpose:
//   Shares one FIFO-fronted UART transmitter between two FIFO-style byte
//   sources. Grants are round-robin and message-granular: once a source owns
//   the transmitter it keeps it until it sends an end-of-message byte, uses up
//   its byte budget, or sits empty for an idle timeout. Messages from the two
//   sources therefore never interleave.
//
// Ports:
//   clk         in   1     system clock
//   rst_n       in   1     asynchronous active-low reset
//   req0_empty  in   1     source 0 FIFO empty
//   req0_data   in   DBIT  source 0 FIFO head byte
//   req0_rd     out  1     source 0 pop strobe
//   req1_empty  in   1     source 1 FIFO empty
//   req1_data   in   DBIT  source 1 FIFO head byte
//   req1_rd     out  1     source 1 pop strobe
//   tx_full     in   1     UART TX FIFO full
//   wr_uart     out  1     UART TX write strobe
//   wr_data     out  DBIT  UART TX byte
//   grant       out  2     one-hot owner (01 = src0, 10 = src1, 00 = none)
//
// Optional build macro UART_TX_ARB_STATS_EN adds:
//   cnt0        out  16    saturating byte count sent for source 0
//   cnt1        out  16    saturating byte count sent for source 1
//   tmo_evt     out  1     one-cycle pulse after each timeout-driven release
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int              DBIT     = 8,
    parameter logic [DBIT-1:0] EOP_BYTE = DBIT'(8'h0D),
    parameter int              HOLD_MAX = 32,
    parameter int              TIMEOUT  = 200
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_empty,
    input  logic [DBIT-1:0] req0_data,
    output logic            req0_rd,
    input  logic            req1_empty,
    input  logic [DBIT-1:0] req1_data,
    output logic            req1_rd,
    input  logic            tx_full,
    output logic            wr_uart,
    output logic [DBIT-1:0] wr_data,
    output logic [1:0]      grant
`ifdef UART_TX_ARB_STATS_EN
    ,
    output logic [15:0]     cnt0,
    output logic [15:0]     cnt1,
    output logic            tmo_evt
`endif
);

    // state  | meaning
    // -------+-----------------------------------------------------------
    // IDLE   | no owner; arbitrate between non-empty sources
    // G0     | source 0 owns the UART until EOP, byte budget or timeout
    // G1     | source 1 owns the UART until EOP, byte budget or timeout

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_G0   = 2'd1,
        S_G1   = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_MAX_C = 8'(HOLD_MAX);
    localparam logic [7:0] TIMEOUT_C  = 8'(TIMEOUT);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_last;
    logic            w_last_nxt;
    logic [7:0]      r_bcnt;
    logic [7:0]      w_bcnt_nxt;
    logic [7:0]      r_icnt;
    logic [7:0]      w_icnt_nxt;

    logic            w_granted;
    logic            w_src_empty;
    logic [DBIT-1:0] w_src_data;
    logic            w_xfer;
    logic            w_rel_eop;
    logic            w_rel_hold;
    logic            w_rel_tmo;

    // Route the owning source's FIFO view onto a common path; in IDLE the
    // path looks empty with zero data so nothing can be written.
    always_comb begin
        w_granted   = 1'b0;
        w_src_empty = 1'b1;
        w_src_data  = '0;
        case (r_state)
            S_G0: begin
                w_granted   = 1'b1;
                w_src_empty = req0_empty;
                w_src_data  = req0_data;
            end
            S_G1: begin
                w_granted   = 1'b1;
                w_src_empty = req1_empty;
                w_src_data  = req1_data;
            end
            default: begin
                w_granted   = 1'b0;
                w_src_empty = 1'b1;
                w_src_data  = '0;
            end
        endcase
    end

    assign w_xfer     = w_granted & ~w_src_empty & ~tx_full;
    assign w_rel_eop  = w_xfer && (w_src_data == EOP_BYTE);
    // Both budget and timeout release on the cycle whose increment would
    // reach the limit, so the limit counts whole bytes / whole empty cycles.
    assign w_rel_hold = w_xfer && ((r_bcnt + 8'd1) == HOLD_MAX_C);
    assign w_rel_tmo  = w_granted && w_src_empty && ((r_icnt + 8'd1) == TIMEOUT_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
            r_bcnt  <= 8'd0;
            r_icnt  <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_icnt  <= w_icnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_bcnt_nxt  = r_bcnt;
        w_icnt_nxt  = r_icnt;
        case (r_state)
            S_IDLE: begin
                // src0 wins when it is alone, or when both wait and src1 went last.
                if (!req0_empty && (req1_empty || r_last)) begin
                    w_state_nxt = S_G0;
                    w_last_nxt  = 1'b0;
                    w_bcnt_nxt  = 8'd0;
                    w_icnt_nxt  = 8'd0;
                end else if (!req1_empty) begin
                    w_state_nxt = S_G1;
                    w_last_nxt  = 1'b1;
                    w_bcnt_nxt  = 8'd0;
                    w_icnt_nxt  = 8'd0;
                end
            end
            S_G0, S_G1: begin
                if (w_xfer) begin
                    w_bcnt_nxt = r_bcnt + 8'd1;
                    w_icnt_nxt = 8'd0;
                end else if (w_src_empty) begin
                    w_icnt_nxt = r_icnt + 8'd1;
                end
                // tx_full with data pending leaves icnt untouched: that is
                // back-pressure, not an idle source.
                if (w_rel_eop || w_rel_hold || w_rel_tmo) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign req0_rd = w_xfer && (r_state == S_G0);
    assign req1_rd = w_xfer && (r_state == S_G1);
    assign wr_uart = w_xfer;
    assign wr_data = w_src_data;
    assign grant   = {r_state == S_G1, r_state == S_G0};

`ifdef UART_TX_ARB_STATS_EN
    logic [15:0] r_cnt0;
    logic [15:0] r_cnt1;
    logic        r_tmo_evt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt0    <= 16'd0;
            r_cnt1    <= 16'd0;
            r_tmo_evt <= 1'b0;
        end else begin
            if (req0_rd && (r_cnt0 != 16'hFFFF)) begin
                r_cnt0 <= r_cnt0 + 16'd1;
            end
            if (req1_rd && (r_cnt1 != 16'hFFFF)) begin
                r_cnt1 <= r_cnt1 + 16'd1;
            end
            r_tmo_evt <= w_rel_tmo;
        end
    end

    assign cnt0    = r_cnt0;
    assign cnt1    = r_cnt1;
    assign tmo_evt = r_tmo_evt;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Two byte-queue sources feed the arbiter. Every byte pushed into a source is
// also pushed into that source's expected-byte queue. A negedge monitor keeps
// a message-level view of ownership (who owns the UART, bytes sent, empty run
// length) and pops the expected queue whenever the UART is written.
// Build with UART_TX_ARB_STATS_EN to also check cnt0/cnt1/tmo_evt.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int         DBIT     = 8;
    localparam logic [7:0] EOP      = 8'h0D;
    localparam int         HOLD_MAX = 32;
    localparam int         TIMEOUT  = 200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_empty = 1'b1;
    logic [7:0] req0_data = 8'h00;
    logic       req1_empty = 1'b1;
    logic [7:0] req1_data = 8'h00;
    logic       tx_full = 1'b0;
    wire        req0_rd;
    wire        req1_rd;
    wire        wr_uart;
    wire  [7:0] wr_data;
    wire  [1:0] grant;
`ifdef UART_TX_ARB_STATS_EN
    wire [15:0] cnt0;
    wire [15:0] cnt1;
    wire        tmo_evt;
`endif

    uart_tx_arbiter #(
        .DBIT     (DBIT),
        .EOP_BYTE (EOP),
        .HOLD_MAX (HOLD_MAX),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_empty (req0_empty),
        .req0_data  (req0_data),
        .req0_rd    (req0_rd),
        .req1_empty (req1_empty),
        .req1_data  (req1_data),
        .req1_rd    (req1_rd),
        .tx_full    (tx_full),
        .wr_uart    (wr_uart),
        .wr_data    (wr_data),
        .grant      (grant)
`ifdef UART_TX_ARB_STATS_EN
        ,
        .cnt0       (cnt0),
        .cnt1       (cnt1),
        .tmo_evt    (tmo_evt)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] exp0[$];
    logic [7:0] exp1[$];
    logic       pop0 = 1'b0;
    logic       pop1 = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- source FIFO models ----------------
    always @(negedge clk) begin
        pop0 = req0_rd;
        pop1 = req1_rd;
    end

    always @(posedge clk) begin
        #1;
        if (pop0 && q0.size() > 0) void'(q0.pop_front());
        if (pop1 && q1.size() > 0) void'(q1.pop_front());
        #1;
        req0_empty = (q0.size() == 0);
        req0_data  = (q0.size() > 0) ? q0[0] : 8'h00;
        req1_empty = (q1.size() == 0);
        req1_data  = (q1.size() > 0) ? q1[0] : 8'h00;
    end

    // ---------------- monitor / reference model ----------------
    int         m_owner = -1;
    bit         m_last = 1'b1;
    int         m_bytes = 0;
    int         m_idle = 0;
    bit         m_tmo_pend = 1'b0;
    logic [15:0] m_cnt0 = 16'd0;
    logic [15:0] m_cnt1 = 16'd0;
    logic       m_empty;
    logic       m_xfer;
    logic [7:0] m_b;
    bit         m_rel;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_owner    = -1;
            m_last     = 1'b1;
            m_bytes    = 0;
            m_idle     = 0;
            m_tmo_pend = 1'b0;
            m_cnt0     = 16'd0;
            m_cnt1     = 16'd0;
        end else begin
            chk("grant", 32'(grant),
                32'((m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00));
`ifdef UART_TX_ARB_STATS_EN
            chk("cnt0", 32'(cnt0), 32'(m_cnt0));
            chk("cnt1", 32'(cnt1), 32'(m_cnt1));
            chk("tmo_evt", 32'(tmo_evt), 32'(m_tmo_pend));
`endif
            m_tmo_pend = 1'b0;
            if (m_owner < 0) begin
                chk("idle_wr_uart", 32'(wr_uart), 32'd0);
                chk("idle_rd", 32'({req1_rd, req0_rd}), 32'd0);
                chk("idle_wr_data", 32'(wr_data), 32'd0);
                if (!req0_empty && (req1_empty || m_last)) m_owner = 0;
                else if (!req1_empty) m_owner = 1;
                if (m_owner >= 0) begin
                    m_last  = (m_owner == 1);
                    m_bytes = 0;
                    m_idle  = 0;
                end
            end else begin
                m_empty = (m_owner == 0) ? req0_empty : req1_empty;
                m_xfer  = !m_empty && !tx_full;
                m_rel   = 1'b0;
                chk("wr_uart", 32'(wr_uart), 32'(m_xfer));
                chk("rd_owner", 32'((m_owner == 0) ? req0_rd : req1_rd), 32'(m_xfer));
                chk("rd_other", 32'((m_owner == 0) ? req1_rd : req0_rd), 32'd0);
                if (m_xfer) begin
                    if ((m_owner == 0 && exp0.size() == 0) || (m_owner == 1 && exp1.size() == 0)) begin
                        chk("sb_underflow", 32'd1, 32'd0);
                        m_b = 8'h00;
                    end else begin
                        m_b = (m_owner == 0) ? exp0.pop_front() : exp1.pop_front();
                        chk("wr_data", 32'(wr_data), 32'(m_b));
                    end
                    if (m_owner == 0 && m_cnt0 != 16'hFFFF) m_cnt0 = m_cnt0 + 16'd1;
                    if (m_owner == 1 && m_cnt1 != 16'hFFFF) m_cnt1 = m_cnt1 + 16'd1;
                    m_bytes++;
                    m_idle = 0;
                    if (m_b == EOP || m_bytes == HOLD_MAX) m_rel = 1'b1;
                end else if (m_empty) begin
                    m_idle++;
                    if (m_idle == TIMEOUT) begin
                        m_rel      = 1'b1;
                        m_tmo_pend = 1'b1;
                    end
                end
                if (m_rel) m_owner = -1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic at_edge();
        @(posedge clk);
        #3;
    endtask

    task automatic push0(input logic [7:0] b);
        q0.push_back(b);
        exp0.push_back(b);
    endtask

    task automatic push1(input logic [7:0] b);
        q1.push_back(b);
        exp1.push_back(b);
    endtask

    function automatic logic [7:0] rand_byte();
        if ($urandom_range(0, 7) == 0) return EOP;
        return 8'($urandom_range(0, 255));
    endfunction

    task automatic wait_quiet(input string name, input int maxc);
        bit done;
        done = 1'b0;
        for (int k = 0; k < maxc && !done; k++) begin
            at_edge();
            if (q0.size() == 0 && q1.size() == 0 && grant == 2'b00) done = 1'b1;
        end
        chk(name, 32'(done), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) at_edge();

        // single CR-terminated message from src0
        push0(8'h41); push0(8'h42); push0(EOP);
        rst_n = 1'b1;
        wait_quiet("quiet_ab_cr", 50);

        // both sources waiting right at reset release
        rst_n = 1'b0;
        at_edge();
        push0(8'h31); push0(8'h32); push0(EOP);
        push1(8'h61); push1(8'h62); push1(EOP);
        rst_n = 1'b1;
        wait_quiet("quiet_both", 60);

        // 50-cycle back-pressure mid-message
        push0(8'h50); push0(8'h51); push0(8'h52); push0(8'h53); push0(EOP);
        repeat (3) at_edge();
        tx_full = 1'b1;
        repeat (50) at_edge();
        tx_full = 1'b0;
        wait_quiet("quiet_stall", 60);

        // timeout release with src1 waiting
        push0(8'h5A);
        repeat (20) at_edge();
        push1(8'h6F); push1(8'h6B); push1(EOP);
        wait_quiet("quiet_timeout", 600);

        // byte-budget release: src1 streams 40 bytes, src0 waits
        for (int i = 0; i < 40; i++) push1(8'h20 + 8'(i));
        repeat (4) at_edge();
        push0(8'h68); push0(8'h69); push0(EOP);
        wait_quiet("quiet_budget", 1000);

        // randomized traffic with random back-pressure
        for (int c = 0; c < 3000; c++) begin
            at_edge();
            tx_full = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0 && q0.size() < 20) push0(rand_byte());
            if ($urandom_range(0, 5) == 0 && q1.size() < 20) push1(rand_byte());
        end
        tx_full = 1'b0;
        wait_quiet("quiet_random", 6000);

        // asynchronous reset in the middle of a message
        for (int i = 0; i < 10; i++) push0(8'h70 + 8'(i));
        repeat (4) at_edge();
        rst_n = 1'b0;
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_wr_uart", 32'(wr_uart), 32'd0);
        chk("rst_rd0", 32'(req0_rd), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
`ifdef UART_TX_ARB_STATS_EN
        chk("rst_cnt0", 32'(cnt0), 32'd0);
        chk("rst_cnt1", 32'(cnt1), 32'd0);
        chk("rst_tmo_evt", 32'(tmo_evt), 32'd0);
`endif
        q0.delete(); exp0.delete();
        q1.delete(); exp1.delete();
        repeat (2) at_edge();
        rst_n = 1'b1;
        push1(8'h7A); push1(EOP);
        wait_quiet("quiet_after_rst", 50);

        chk("exp0_drained", 32'(exp0.size()), 32'd0);
        chk("exp1_drained", 32'(exp1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
